mdu_seq: RTL and testbench

Iterative RV32M multiply/divide sequencer for the Execute stage of the 5-stage RV32I pipeline. It accepts one M-extension operation from Execute, runs a 32-iteration shift-add multiply or restoring divide on latched operand magnitudes, and applies sign correction. It holds the pipeline stalled until the 32-bit result is ready, then releases Execute so the instruction advances with that result. It sits beside the ALU and is muxed onto the Execute result path by the pipeline.

---
 rtl/mdu_pkg.sv | 38 +++
 rtl/mdu_if.sv | 28 ++
 rtl/mdu_step.sv | 58 +++++
 rtl/mdu_seq.sv | 177 +++++++++++++++++
 tb/tb_mdu_seq.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared constants, state encoding and helpers for the RV32M sequencer
// Purpose: funct3 op codes, FSM states, iteration sizing, divide special-case
//          constants and two's-complement negate helpers used by mdu_seq/mdu_step.
// Ports:   none (package).
package mdu_pkg;

  localparam int XLEN  = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 6;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [31:0] DIV_ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV_INT_MIN  = 32'h8000_0000;

  function automatic logic [31:0] neg32(input logic en, input logic [31:0] v);
    return en ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic en, input logic [63:0] v);
    return en ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - Execute-stage handshake bundle between the pipeline and mdu_seq
// Purpose: groups the M-extension request, operands, flush and the stall/result
//          return path.
// Ports:   master = Execute side (drives MdStartE, funct3E, SrcAE, SrcBE, FlushE);
//          slave  = sequencer side (drives StallMD, MdBusy, MdValid, MdResultE).
interface mdu_if;

  logic        MdStartE;
  logic [2:0]  funct3E;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        FlushE;
  logic        StallMD;
  logic        MdBusy;
  logic        MdValid;
  logic [31:0] MdResultE;

  modport master (
    output MdStartE, funct3E, SrcAE, SrcBE, FlushE,
    input  StallMD, MdBusy, MdValid, MdResultE
  );

  modport slave (
    input  MdStartE, funct3E, SrcAE, SrcBE, FlushE,
    output StallMD, MdBusy, MdValid, MdResultE
  );

endinterface

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one combinational iteration of shift-add multiply / restoring divide
// Purpose: next value of the {hi, lo} working register for one CALC cycle.
//          Multiply: hi = running high product, lo = multiplier shifting out.
//          Divide:   hi = partial remainder, lo = dividend shifting out / quotient in.
// Ports:   is_div (select divide), hi_in/lo_in (working register), opb (multiplicand
//          or divisor magnitude), hi_out/lo_out (next working register).
// Config:  MDU_DIV_EN defined compiles the divide path; otherwise multiply only.
module mdu_step
  import mdu_pkg::*;
(
  input  logic            is_div,
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  // Carry out of the add becomes the top bit after the right shift.
  logic [XLEN:0] sum;

  always_comb begin
    sum = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
  end

`ifdef MDU_DIV_EN
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // The remainder stays below the divisor, so the shifted value fits in 33 bits
  // and a clear borrow bit means the trial subtract succeeded.
  always_comb begin
    shifted = {hi_in, lo_in[XLEN-1]};
    trial   = shifted - {1'b0, opb};
    if (is_div) begin
      if (!trial[XLEN]) begin
        hi_out = trial[XLEN-1:0];
        lo_out = {lo_in[XLEN-2:0], 1'b1};
      end else begin
        hi_out = shifted[XLEN-1:0];
        lo_out = {lo_in[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_out = sum[XLEN:1];
      lo_out = {sum[0], lo_in[XLEN-1:1]};
    end
  end
`else
  logic unused_is_div;
  assign unused_is_div = is_div;

  always_comb begin
    hi_out = sum[XLEN:1];
    lo_out = {sum[0], lo_in[XLEN-1:1]};
  end
`endif

endmodule

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative RV32M multiply/divide sequencer for the Execute stage
// Purpose: latches one M-extension op, runs 32 iterations on operand magnitudes,
//          sign-corrects in FIX, pulses MdValid in DONE and stalls the pipeline
//          until then.
// Ports:   clk, rst (sync active-high); md (mdu_if.slave): MdStartE, funct3E,
//          SrcAE, SrcBE, FlushE in; StallMD, MdBusy, MdValid, MdResultE out.
// Config:  MDU_DIV_EN defined enables DIV/DIVU/REM/REMU; undefined, funct3 1xx
//          completes in one cycle with a zero result.
module mdu_seq
  import mdu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  mdu_if.slave  md
);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op;
  logic [XLEN-1:0]  hi, lo, opb;
  logic             neg_res;
  logic [XLEN-1:0]  result;
  logic [XLEN-1:0]  step_hi, step_lo;

  logic             start;
  logic             a_sgn, b_sgn;
  logic [XLEN-1:0]  abs_a, abs_b;
  logic             special;
  logic [XLEN-1:0]  special_res;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]  fix_res;

`ifdef MDU_DIV_EN
  logic             rem_neg;
  logic             div_by_zero, div_ovf;
  logic [XLEN-1:0]  quo, rem;
`endif

  assign start = md.MdStartE & ~md.FlushE;

  // MUL is treated as signed x signed: the low word is identical either way.
  always_comb begin
    a_sgn = md.SrcAE[XLEN-1] & (md.funct3E inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
    b_sgn = md.SrcBE[XLEN-1] & (md.funct3E inside {MD_MUL, MD_MULH, MD_DIV, MD_REM});
    abs_a = neg32(a_sgn, md.SrcAE);
    abs_b = neg32(b_sgn, md.SrcBE);
  end

`ifdef MDU_DIV_EN
  always_comb begin
    div_by_zero = md.funct3E[2] & (md.SrcBE == '0);
    div_ovf     = (md.funct3E == MD_DIV || md.funct3E == MD_REM) &&
                  (md.SrcAE == DIV_INT_MIN) && (md.SrcBE == DIV_ALL_ONES);
    special     = div_by_zero | div_ovf;
    // funct3[1] distinguishes remainder ops from quotient ops.
    if (div_by_zero) begin
      special_res = md.funct3E[1] ? md.SrcAE : DIV_ALL_ONES;
    end else begin
      special_res = md.funct3E[1] ? '0 : DIV_INT_MIN;
    end
  end
`else
  always_comb begin
    special     = md.funct3E[2];
    special_res = '0;
  end
`endif

  always_comb begin
    product = neg64(neg_res, {hi, lo});
    fix_res = (op == MD_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
    quo = neg32(neg_res, lo);
    rem = neg32(rem_neg, hi);
    if (op[2]) begin
      fix_res = op[1] ? rem : quo;
    end
`endif
  end

  mdu_step u_step (
    .is_div (op[2]),
    .hi_in  (hi),
    .lo_in  (lo),
    .opb    (opb),
    .hi_out (step_hi),
    .lo_out (step_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = special ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        // Flush takes priority over leaving on the final iteration.
        if (md.FlushE) begin
          state_next = ST_IDLE;
        end else if (cnt == CNT_W'(ITER-1)) begin
          state_next = ST_FIX;
        end
      end
      ST_FIX: begin
        state_next = md.FlushE ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      op      <= '0;
      hi      <= '0;
      lo      <= '0;
      opb     <= '0;
      neg_res <= 1'b0;
      result  <= '0;
`ifdef MDU_DIV_EN
      rem_neg <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op      <= md.funct3E;
            hi      <= '0;
            lo      <= abs_a;
            opb     <= abs_b;
            neg_res <= a_sgn ^ b_sgn;
            cnt     <= '0;
`ifdef MDU_DIV_EN
            rem_neg <= a_sgn;
`endif
            if (special) begin
              result <= special_res;
            end
          end
        end
        ST_CALC: begin
          hi  <= step_hi;
          lo  <= step_lo;
          cnt <= cnt + CNT_W'(1);
        end
        ST_FIX: begin
          if (!md.FlushE) begin
            result <= fix_res;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign md.StallMD   = ((state == ST_IDLE) & start) | (state == ST_CALC) | (state == ST_FIX);
  assign md.MdBusy    = (state != ST_IDLE);
  assign md.MdValid   = (state == ST_DONE);
  assign md.MdResultE = result;

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - self-checking bench for mdu_seq
module tb_mdu_seq;
  import mdu_pkg::*;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdu_if md();

  mdu_seq dut (
    .clk (clk),
    .rst (rst),
    .md  (md)
  );

  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] last_exp = 32'h0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic bit is_ovf(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return (f3 == MD_DIV || f3 == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Reference: plain 64-bit arithmetic and SV signed division (truncates to zero).
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic signed [31:0] sa32, sb32;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    sa32 = a;
    sb32 = b;
    case (f3)
      MD_MUL:    begin p = ua * ub; return p[31:0]; end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub; return p[63:32]; end
      MD_MULHU:  begin p = ua * ub; return p[63:32]; end
      default: begin
        if (!DIV_EN) return 32'h0;
        if (b == 32'h0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (is_ovf(f3, a, b)) return f3[1] ? 32'h0 : 32'h8000_0000;
        case (f3)
          MD_DIV:  return sa32 / sb32;
          MD_REM:  return sa32 % sb32;
          MD_DIVU: return a / b;
          default: return a % b;
        endcase
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (!DIV_EN || b == 32'h0 || is_ovf(f3, a, b))) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the MdValid pulse.
  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cyc;
    bit hs_bad;
    md.funct3E  = f3;
    md.SrcAE    = a;
    md.SrcBE    = b;
    md.FlushE   = 1'b0;
    md.MdStartE = 1'b1;
    #1;
    chk({nm, " stall_c0"}, md.StallMD, 1);
    tick();
    md.MdStartE = 1'b0;
    cyc = 1;
    hs_bad = 1'b0;
    while (md.MdValid !== 1'b1 && cyc < 200) begin
      if (md.StallMD !== 1'b1 || md.MdBusy !== 1'b1) hs_bad = 1'b1;
      tick();
      cyc++;
    end
    chk({nm, " latency"}, cyc, lat);
    chk({nm, " result"}, md.MdResultE, exp);
    chk({nm, " stall_done"}, {md.StallMD, md.MdBusy}, 2'b01);
    chk({nm, " stall_busy_during"}, hs_bad, 0);
    tick();
    chk({nm, " idle_after"}, {md.MdValid, md.MdBusy}, 2'b00);
    last_exp = exp;
  endtask

  // Starts a MUL, asserts FlushE in cycle fc, checks the idle cycle that follows.
  task automatic flush_seq(input string nm, input int fc);
    bit early_valid;
    md.funct3E  = MD_MUL;
    md.SrcAE    = 32'd3;
    md.SrcBE    = 32'd5;
    md.FlushE   = 1'b0;
    md.MdStartE = 1'b1;
    tick();
    md.MdStartE = 1'b0;
    early_valid = 1'b0;
    for (int c = 1; c < fc; c++) begin
      if (md.MdValid !== 1'b0) early_valid = 1'b1;
      tick();
    end
    md.FlushE = 1'b1;
    tick();
    md.FlushE = 1'b0;
    chk({nm, " no_valid_before"}, early_valid, 0);
    chk({nm, " idle_after_flush"}, {md.StallMD, md.MdBusy, md.MdValid}, 3'b000);
    chk({nm, " result_held"}, md.MdResultE, last_exp);
    tick();
    chk({nm, " still_idle"}, {md.MdBusy, md.MdValid}, 2'b00);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b, e;
    logic [2:0]  rop;
    bit late_valid;

    tbl[0]  = '{MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    tbl[1]  = '{MD_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
    tbl[2]  = '{MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    tbl[3]  = '{MD_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34};
    tbl[4]  = '{MD_DIV,    32'hFFFF_FFF9,  32'd2,         DIV_EN ? 32'hFFFF_FFFD : 32'h0, DIV_EN ? 34 : 1};
    tbl[5]  = '{MD_REM,    32'hFFFF_FFF9,  32'd2,         DIV_EN ? 32'hFFFF_FFFF : 32'h0, DIV_EN ? 34 : 1};
    tbl[6]  = '{MD_DIVU,   32'd100,        32'd7,         DIV_EN ? 32'd14 : 32'h0,        DIV_EN ? 34 : 1};
    tbl[7]  = '{MD_REMU,   32'd100,        32'd7,         DIV_EN ? 32'd2 : 32'h0,         DIV_EN ? 34 : 1};
    tbl[8]  = '{MD_DIVU,   32'd5,          32'd0,         DIV_EN ? 32'hFFFF_FFFF : 32'h0, 1};
    tbl[9]  = '{MD_REM,    32'd5,          32'd0,         DIV_EN ? 32'd5 : 32'h0,         1};
    tbl[10] = '{MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, DIV_EN ? 32'h8000_0000 : 32'h0, 1};

    md.MdStartE = 1'b0;
    md.FlushE   = 1'b0;
    md.funct3E  = 3'b000;
    md.SrcAE    = 32'h0;
    md.SrcBE    = 32'h0;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", {md.StallMD, md.MdBusy, md.MdValid}, 3'b000);
    chk("reset_result", md.MdResultE, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("tbl%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);
    end

    // Start with FlushE in the same cycle must not launch anything.
    md.funct3E  = MD_MUL;
    md.SrcAE    = 32'd9;
    md.SrcBE    = 32'd9;
    md.FlushE   = 1'b1;
    md.MdStartE = 1'b1;
    #1;
    chk("start_flushed stall", md.StallMD, 0);
    tick();
    md.MdStartE = 1'b0;
    md.FlushE   = 1'b0;
    chk("start_flushed idle", {md.MdBusy, md.MdValid}, 2'b00);
    chk("start_flushed result", md.MdResultE, last_exp);

    run_op("mul_pre_flush", MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    flush_seq("flush_c10", 10);
    // Cycle 12 relative to the flushed start.
    run_op("divu_after_flush", MD_DIVU, 32'd100, 32'd7, ref_result(MD_DIVU, 32'd100, 32'd7),
           ref_lat(MD_DIVU, 32'd100, 32'd7));
    flush_seq("flush_last_calc", 32);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      e  = ref_result(f3, a, b);
      run_op($sformatf("rnd%0d f3=%0d a=%0h b=%0h", i, f3, a, b), f3, a, b, e, ref_lat(f3, a, b));
    end

    // Reset in cycle 20 of a long op.
    run_op("mul_pre_rst", MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    rop = DIV_EN ? MD_DIV : MD_MULHU;
    md.funct3E  = rop;
    md.SrcAE    = 32'd100;
    md.SrcBE    = 32'd7;
    md.MdStartE = 1'b1;
    tick();
    md.MdStartE = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid outputs", {md.StallMD, md.MdBusy, md.MdValid}, 3'b000);
    chk("rst_mid result", md.MdResultE, 32'h0);
    late_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (md.MdValid !== 1'b0 || md.MdBusy !== 1'b0) late_valid = 1'b1;
      tick();
    end
    chk("rst_mid no_valid", late_valid, 0);

    run_op("div9_3", MD_DIV, 32'd9, 32'd3, ref_result(MD_DIV, 32'd9, 32'd3), ref_lat(MD_DIV, 32'd9, 32'd3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
